// File: rtl/oled_fb_streamer.sv
// Streams the SSD1306 address-window commands, then the whole framebuffer, to the SPI master one byte per handshake.
// Optional periodic refresh tick: define OLED_FB_AUTOREFRESH_EN (period REFRESH_DIV cycles of clk_50M).
module oled_fb_streamer #(
  parameter int          NUM_COLS    = 128,
  parameter int          NUM_PAGES   = 8,
  parameter int          ADDR_W      = 10,
  parameter logic [23:0] REFRESH_DIV = 24'd833_333
) (
  input  logic              clk_50M,
  input  logic              rst_n,
  input  logic              init_done,
  input  logic              frame_start,
  output logic [ADDR_W-1:0] fb_rd_addr,
  output logic              fb_rd_en,
  input  logic [7:0]        fb_rd_data,
  output logic [7:0]        spi_tx_data,
  output logic              spi_wr,
  input  logic              spi_done,
  output logic              oled_dc,
  output logic              busy,
  output logic              frame_done
);

  localparam logic [ADDR_W-1:0] LAST_BYTE = ADDR_W'(NUM_COLS * NUM_PAGES - 1);

  typedef enum logic [2:0] {
    IDLE, CMD_LOAD, CMD_WAIT, RD_REQ, RD_LATCH, DATA_WAIT, DONE
  } state_t;

  state_t            state;
  logic [2:0]        cmd_idx;
  logic [ADDR_W-1:0] byte_cnt;
  logic [7:0]        cmd_byte;
  logic              start;

  // Column window 0..NUM_COLS-1, page window 0..NUM_PAGES-1.
  always_comb begin
    cmd_byte = 8'h00;
    case (cmd_idx)
      3'd0:    cmd_byte = 8'h21;
      3'd2:    cmd_byte = 8'(NUM_COLS - 1);
      3'd3:    cmd_byte = 8'h22;
      3'd5:    cmd_byte = 8'(NUM_PAGES - 1);
      default: cmd_byte = 8'h00;
    endcase
  end

`ifdef OLED_FB_AUTOREFRESH_EN
  localparam logic [23:0] REFRESH_RELOAD = REFRESH_DIV - 24'd1;
  logic [23:0] refresh_cnt;
  logic        refresh_tick;

  // A tick that lands while a frame is in flight is simply not accepted by IDLE.
  assign refresh_tick = init_done && (refresh_cnt == 24'd0);
  assign start        = frame_start | refresh_tick;

  always_ff @(posedge clk_50M or negedge rst_n) begin
    if (!rst_n) begin
      refresh_cnt <= REFRESH_RELOAD;
    end else if (init_done) begin
      if (refresh_cnt == 24'd0) refresh_cnt <= REFRESH_RELOAD;
      else                      refresh_cnt <= refresh_cnt - 24'd1;
    end
  end
`else
  logic unused_refresh_div;
  assign unused_refresh_div = ^REFRESH_DIV;
  assign start              = frame_start;
`endif

  // fb_rd_en is raised on entry to RD_REQ so the RAM word is ready by the RD_LATCH edge.
  always_ff @(posedge clk_50M or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      fb_rd_addr  <= '0;
      fb_rd_en    <= 1'b0;
      spi_tx_data <= 8'h00;
      spi_wr      <= 1'b0;
      oled_dc     <= 1'b0;
      busy        <= 1'b0;
      frame_done  <= 1'b0;
      cmd_idx     <= 3'd0;
      byte_cnt    <= '0;
    end else begin
      spi_wr     <= 1'b0;
      fb_rd_en   <= 1'b0;
      frame_done <= 1'b0;
      case (state)
        IDLE: begin
          if (start && init_done) begin
            busy    <= 1'b1;
            cmd_idx <= 3'd0;
            oled_dc <= 1'b0;
            state   <= CMD_LOAD;
          end
        end
        CMD_LOAD: begin
          spi_tx_data <= cmd_byte;
          spi_wr      <= 1'b1;
          state       <= CMD_WAIT;
        end
        CMD_WAIT: begin
          if (spi_done) begin
            if (cmd_idx == 3'd5) begin
              oled_dc    <= 1'b1;
              byte_cnt   <= '0;
              fb_rd_addr <= '0;
              fb_rd_en   <= 1'b1;
              state      <= RD_REQ;
            end else begin
              cmd_idx <= cmd_idx + 3'd1;
              state   <= CMD_LOAD;
            end
          end
        end
        RD_REQ: begin
          state <= RD_LATCH;
        end
        RD_LATCH: begin
          spi_tx_data <= fb_rd_data;
          spi_wr      <= 1'b1;
          state       <= DATA_WAIT;
        end
        DATA_WAIT: begin
          if (spi_done) begin
            if (byte_cnt == LAST_BYTE) begin
              state <= DONE;
            end else begin
              byte_cnt   <= byte_cnt + 1'b1;
              fb_rd_addr <= fb_rd_addr + 1'b1;
              fb_rd_en   <= 1'b1;
              state      <= RD_REQ;
            end
          end
        end
        DONE: begin
          frame_done <= 1'b1;
          busy       <= 1'b0;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_oled_fb_streamer.sv
// Directed bench for oled_fb_streamer: SPI responder with programmable delay, RAM returning addr[7:0].
module tb_oled_fb_streamer;

  logic       clk_50M = 1'b0;
  logic       rst_n = 1'b0;
  logic       init_done = 1'b0;
  logic       frame_start = 1'b0;
  logic [9:0] fb_rd_addr;
  logic       fb_rd_en;
  logic [7:0] fb_rd_data = 8'h00;
  logic [7:0] spi_tx_data;
  logic       spi_wr;
  logic       spi_done;
  logic       oled_dc;
  logic       busy;
  logic       frame_done;

  logic done_model = 1'b0, done_stray = 1'b0, done_idle = 1'b0;
  assign spi_done = done_model | done_stray | done_idle;

  oled_fb_streamer dut (
    .clk_50M(clk_50M), .rst_n(rst_n), .init_done(init_done), .frame_start(frame_start),
    .fb_rd_addr(fb_rd_addr), .fb_rd_en(fb_rd_en), .fb_rd_data(fb_rd_data),
    .spi_tx_data(spi_tx_data), .spi_wr(spi_wr), .spi_done(spi_done),
    .oled_dc(oled_dc), .busy(busy), .frame_done(frame_done)
  );

  always #10 clk_50M = ~clk_50M;

  always @(posedge clk_50M) if (fb_rd_en) fb_rd_data <= fb_rd_addr[7:0];

  int checks = 0, failures = 0;
  logic [7:0] q_dat[$];
  logic       q_dc[$];
  logic [9:0] q_addr[$];
  int   spi_delay = 20, pend = 0, cyc = 0, last_done = 0;
  logic in_flight = 1'b0, have_done = 1'b0, prev_dc = 1'b0, stray_arm = 1'b0;
  logic [7:0] held_dat = 8'h00;
  logic       held_dc = 1'b0;
  int   stab_err = 0, dc_err = 0, lat_err = 0, fd_busy_err = 0, fd_cnt = 0;
  int   stray_req = 0, stray_served = 0;

  // Monitor and SPI responder share one process so their ordering is fixed.
  always @(negedge clk_50M) begin
    cyc++;
    done_model = 1'b0;
    done_stray = 1'b0;
    if (!rst_n) begin
      pend = 0; in_flight = 1'b0; stray_arm = 1'b0; have_done = 1'b0; prev_dc = oled_dc;
    end else begin
      if (stray_arm) begin done_stray = 1'b1; stray_arm = 1'b0; end
      if (in_flight && !spi_wr && (spi_tx_data !== held_dat || oled_dc !== held_dc)) stab_err++;
      if (spi_wr) begin
        q_dat.push_back(spi_tx_data);
        q_dc.push_back(oled_dc);
        q_addr.push_back(fb_rd_addr);
        if (oled_dc !== prev_dc) dc_err++;
        if (have_done && (cyc - last_done) != (oled_dc ? 3 : 2)) lat_err++;
        have_done = 1'b0;
        held_dat = spi_tx_data; held_dc = oled_dc; in_flight = 1'b1; pend = spi_delay;
      end else if (pend > 0) begin
        pend--;
        if (pend == 0) begin
          done_model = 1'b1; in_flight = 1'b0; have_done = 1'b1; last_done = cyc;
          if (stray_req > stray_served) begin stray_served++; stray_arm = 1'b1; end
        end
      end
      if (frame_done) begin fd_cnt++; if (busy !== 1'b0) fd_busy_err++; end
      prev_dc = oled_dc;
    end
  end

  task automatic pulse_start();
    @(negedge clk_50M) frame_start = 1'b1;
    @(negedge clk_50M) frame_start = 1'b0;
  endtask

  task automatic wait_wr(input int target, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(posedge clk_50M);
      if (q_dat.size() >= target) begin ok = 1'b1; break; end
    end
  endtask

  task automatic wait_fd(input int target, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(posedge clk_50M);
      if (fd_cnt >= target) begin ok = 1'b1; break; end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk_50M);
    checks++;
    if ({fb_rd_addr, fb_rd_en, spi_tx_data, spi_wr, oled_dc, busy, frame_done} !== 23'd0) begin
      failures++;
      $display("FAIL reset_outputs got=%h want=0",
               {fb_rd_addr, fb_rd_en, spi_tx_data, spi_wr, oled_dc, busy, frame_done});
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk_50M);
  endtask

  task automatic test_refuse_uninit();
    int  base;
    bit  busy_seen;
    base = q_dat.size();
    busy_seen = 1'b0;
    init_done = 1'b0;
    pulse_start();
    repeat (40) begin
      @(negedge clk_50M);
      if (busy) busy_seen = 1'b1;
    end
    checks++;
    if (q_dat.size() != base) begin
      failures++; $display("FAIL uninit_spi_wr got=%0d want=0", q_dat.size() - base);
    end
    checks++;
    if (busy_seen) begin failures++; $display("FAIL uninit_busy got=1 want=0"); end
  endtask

  task automatic test_stray_idle();
    int base;
    base = q_dat.size();
    init_done = 1'b1;
    @(negedge clk_50M) done_idle = 1'b1;
    @(negedge clk_50M) done_idle = 1'b0;
    repeat (20) @(negedge clk_50M);
    checks++;
    if (q_dat.size() != base || busy !== 1'b0) begin
      failures++;
      $display("FAIL stray_idle wr=%0d busy=%b want wr=0 busy=0", q_dat.size() - base, busy);
    end
  endtask

  task automatic test_frame();
    int         base, fd0, bad_idx;
    bit         ok;
    logic [7:0] exp_cmd [6];
    exp_cmd = '{8'h21, 8'h00, 8'h7F, 8'h22, 8'h00, 8'h07};
    spi_delay = 20;
    base = q_dat.size();
    fd0 = fd_cnt;
    pulse_start();
    wait_wr(base + 16, 2000, ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL frame_reach_byte10 got=%0d want=16", q_dat.size() - base); end
    pulse_start();
    wait_wr(base + 26, 2000, ok);
    stray_req++;
    wait_fd(fd0 + 1, 40000, ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL frame_done_timeout got=%0d want=1", fd_cnt - fd0); end
    repeat (100) @(negedge clk_50M);
    checks++;
    if (q_dat.size() - base != 1030) begin
      failures++; $display("FAIL frame_wr_total got=%0d want=1030", q_dat.size() - base);
    end
    checks++;
    if (fd_cnt - fd0 != 1) begin failures++; $display("FAIL frame_done_count got=%0d want=1", fd_cnt - fd0); end
    if (q_dat.size() - base >= 6) begin
      for (int i = 0; i < 6; i++) begin
        checks++;
        if (q_dat[base+i] !== exp_cmd[i] || q_dc[base+i] !== 1'b0) begin
          failures++;
          $display("FAIL cmd_byte%0d got=%h dc=%b want=%h dc=0", i, q_dat[base+i], q_dc[base+i], exp_cmd[i]);
        end
      end
    end
    bad_idx = -1;
    for (int i = 0; i < 1024; i++) begin
      if (base + 6 + i >= q_dat.size()) begin bad_idx = i; break; end
      if (q_dat[base+6+i] !== i[7:0] || q_dc[base+6+i] !== 1'b1 || q_addr[base+6+i] !== i[9:0]) begin
        bad_idx = i; break;
      end
    end
    checks++;
    if (bad_idx >= 0) begin
      failures++;
      $display("FAIL data_stream first bad byte %0d want data=%h dc=1 addr=%0d", bad_idx, bad_idx[7:0], bad_idx);
    end
    checks++;
    if (stab_err != 0) begin failures++; $display("FAIL hold_stable got=%0d errors want=0", stab_err); end
    checks++;
    if (dc_err != 0) begin failures++; $display("FAIL dc_setup got=%0d errors want=0", dc_err); end
    checks++;
    if (lat_err != 0) begin failures++; $display("FAIL done_to_wr_latency got=%0d errors want=0", lat_err); end
    checks++;
    if (fd_busy_err != 0) begin failures++; $display("FAIL busy_at_frame_done got=%0d errors want=0", fd_busy_err); end
    checks++;
    if (busy !== 1'b0 || oled_dc !== 1'b1) begin
      failures++; $display("FAIL post_frame busy=%b dc=%b want busy=0 dc=1", busy, oled_dc);
    end
  endtask

  task automatic test_reset_mid();
    int base, fd0;
    bit ok;
    spi_delay = 2;
    base = q_dat.size();
    pulse_start();
    wait_wr(base + 6 + 301, 5000, ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL mid_reach_byte300 got=%0d want=307", q_dat.size() - base); end
    #3 rst_n = 1'b0;
    #1;
    checks++;
    if ({fb_rd_addr, fb_rd_en, spi_tx_data, spi_wr, oled_dc, busy, frame_done} !== 23'd0) begin
      failures++;
      $display("FAIL mid_reset_async got=%h want=0",
               {fb_rd_addr, fb_rd_en, spi_tx_data, spi_wr, oled_dc, busy, frame_done});
    end
    repeat (2) @(negedge clk_50M);
    rst_n = 1'b1;
    repeat (3) @(negedge clk_50M);
    base = q_dat.size();
    fd0 = fd_cnt;
    pulse_start();
    checks++;
    if (spi_wr !== 1'b0) begin failures++; $display("FAIL start_latency_early spi_wr=%b want=0", spi_wr); end
    @(negedge clk_50M);
    checks++;
    if (spi_wr !== 1'b1 || spi_tx_data !== 8'h21 || oled_dc !== 1'b0) begin
      failures++;
      $display("FAIL restart_first wr=%b data=%h dc=%b want wr=1 data=21 dc=0", spi_wr, spi_tx_data, oled_dc);
    end
    wait_fd(fd0 + 1, 10000, ok);
    repeat (20) @(negedge clk_50M);
    checks++;
    if (!ok || q_dat.size() - base != 1030) begin
      failures++; $display("FAIL restart_frame wr=%0d done=%b want wr=1030 done=1", q_dat.size() - base, ok);
    end
  endtask

  initial begin
    test_reset();
    test_refuse_uninit();
    test_stray_idle();
    test_frame();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/oled_fb_streamer.md
Name: oled_fb_streamer

Overview:
- Downstream of the SSD1306 ROM init sequencer and upstream of the SPI master.
- Once init_done is high, each refresh request causes this block to:
  - send the SSD1306 address-window commands (DC=0);
  - stream the whole framebuffer from a synchronous RAM read port (DC=1);
  - issue one SPI byte per handshake.
- Owns oled_dc after init; the init sequencer owns oled_dc before init_done.

Parameters:
- NUM_COLS, 128, display columns (column end address = NUM_COLS-1).
- NUM_PAGES, 8, display pages (page end address = NUM_PAGES-1); frame bytes = NUM_COLS*NUM_PAGES.
- ADDR_W, 10, framebuffer address width; must satisfy 2^ADDR_W >= NUM_COLS*NUM_PAGES.
- REFRESH_DIV, 24'd833_333, clk_50M cycles between auto-refresh starts (optional feature only).

Ports:
- clk_50M  in  1  system clock, 50 MHz
- rst_n  in  1  reset, asynchronous, active-low
- init_done  in  1  level; init sequencer finished; frames are refused while low
- frame_start  in  1  one-cycle pulse; request one full frame transfer
- fb_rd_addr  out  ADDR_W  framebuffer read address
- fb_rd_en  out  1  read strobe; fb_rd_data is valid on the cycle after fb_rd_en
- fb_rd_data  in  8  framebuffer byte; bit0 = top pixel of the page
- spi_tx_data  out  8  byte to the SPI master
- spi_wr  out  1  one-cycle pulse; start transmitting spi_tx_data
- spi_done  in  1  one-cycle pulse from the SPI master when the byte has fully shifted out
- oled_dc  out  1  0 = command, 1 = display data
- busy  out  1  high from frame acceptance until frame_done
- frame_done  out  1  one-cycle pulse after the last data byte's spi_done

Behaviour:
- Reset values (async, rst_n low): state=IDLE, fb_rd_addr=0, fb_rd_en=0, spi_tx_data=0, spi_wr=0, oled_dc=0, busy=0, frame_done=0, cmd_idx=0, byte_cnt=0.
- Reset asserted mid-frame aborts immediately to those values; no partial byte is retried.
- States: IDLE, CMD_LOAD, CMD_WAIT, RD_REQ, RD_LATCH, DATA_WAIT, DONE.
- IDLE:
  - frame_start && init_done -> CMD_LOAD; same edge: busy<=1, cmd_idx<=0, oled_dc<=0.
  - frame_start while init_done=0 or busy=1 is ignored and not queued.
- Command list, 6 bytes: 0x21, 0x00, NUM_COLS-1, 0x22, 0x00, NUM_PAGES-1.
- CMD_LOAD: spi_tx_data<=cmd[cmd_idx]; spi_wr<=1 for exactly one cycle -> CMD_WAIT.
- CMD_WAIT: on spi_done:
  - if cmd_idx==5 -> RD_REQ with oled_dc<=1, byte_cnt<=0, fb_rd_addr<=0;
  - else cmd_idx+=1 -> CMD_LOAD.
- RD_REQ: fb_rd_en<=1 for one cycle -> RD_LATCH.
- RD_LATCH: spi_tx_data<=fb_rd_data; spi_wr pulse -> DATA_WAIT.
- DATA_WAIT: on spi_done:
  - if byte_cnt==NUM_COLS*NUM_PAGES-1 -> DONE;
  - else byte_cnt+=1, fb_rd_addr+=1 -> RD_REQ.
- DONE: frame_done=1 for one cycle, busy<=0, oled_dc holds 1 -> IDLE.
- Handshake rules:
  - spi_tx_data and oled_dc are stable from the spi_wr cycle until the matching spi_done.
  - oled_dc changes at least one cycle before the spi_wr it qualifies.
  - spi_done arriving while not in CMD_WAIT/DATA_WAIT is ignored.
  - No timeout: the block waits indefinitely for spi_done.
- Latency:
  - frame_start to first spi_wr: 2 cycles.
  - spi_done to next spi_wr: 2 cycles for commands, 3 cycles for data.
- Counters: byte_cnt and fb_rd_addr are ADDR_W bits and never wrap inside a frame. fb_rd_addr resets to 0 at each frame.
- init_done falling mid-frame does not abort; the frame completes.

Optional Feature:
- Macro: OLED_FB_AUTOREFRESH_EN.
- Defined:
  - a 24-bit down-counter loads REFRESH_DIV-1 and decrements every cycle while init_done=1;
  - at 0 it reloads and generates an internal start pulse, ORed with frame_start;
  - if busy, that tick is dropped;
  - counter resets to REFRESH_DIV-1 under rst_n.
- Not defined: the counter logic is absent; only frame_start starts frames.

Test Plan:
- Reset mid-frame: rst_n low during byte 300 -> all outputs return to reset values asynchronously; next frame_start restarts with command 0x21.
- Command phase: init_done=1, frame_start pulse, SPI model returns spi_done 20 cycles after each spi_wr -> six spi_wr with oled_dc=0 and bytes 21,00,7F,22,00,07 in order.
- Data phase: RAM holds byte = addr[7:0] -> 1024 spi_wr with oled_dc=1 carrying 00..FF repeating; fb_rd_addr goes 0..1023; frame_done pulses once; busy falls the same cycle.
- Refusal: frame_start with init_done=0 -> no spi_wr and busy stays 0. A second frame_start at byte 10 of an active frame -> ignored; exactly 1030 spi_wr total.
- Stray handshake: spi_done pulsed while in IDLE and while in RD_REQ -> no state change and no extra spi_wr.
- Auto-refresh (OLED_FB_AUTOREFRESH_EN, REFRESH_DIV=5000, spi_done after 2 cycles): frames start every 5000 cycles; any tick landing while busy is skipped.
